// File: rtl/fetch_hazard_ctrl.sv
// Fetch-side hazard controller: gates the PC and IF/ID registers from load-use
// hazards, taken branches resolved in EX and a variable-latency IMEM handshake.
// Control outputs are combinational (they gate the PC/IF/ID enables in the
// same cycle); state, the timeout flag and the performance counters are registered.
module fetch_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned IMEM_TIMEOUT = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             imem_abort,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             imem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned LEFT_W = 2;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(IMEM_TIMEOUT);
  localparam logic [LEFT_W-1:0] RELOAD_V  = LEFT_W'(FLUSH_CYCLES - 1);
  // A single-cycle flush is fully covered by the branch cycle itself.
  localparam logic [1:0]        BR_NEXT   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [1:0]        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [LEFT_W-1:0] flush_left, left_nxt;
  logic              load_use;
  logic              err_set_c;
  logic              stall_inc_c;
  logic              flush_inc_c;
  logic              req_c, abort_c, pc_we_c, ifid_we_c, flush_c, bubble_c;

  // Load in EX whose destination is a source of the instruction in ID.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Next-state and control decode; branch > timeout > load-use > imem not ready.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    left_nxt    = flush_left;
    err_set_c   = 1'b0;
    flush_inc_c = 1'b0;
    req_c       = 1'b0;
    abort_c     = 1'b0;
    pc_we_c     = 1'b0;
    ifid_we_c   = 1'b0;
    flush_c     = 1'b0;
    bubble_c    = 1'b0;

    case (state)
      ST_RUN: begin
        req_c = 1'b1;
        if (branch_taken) begin
          pc_we_c     = 1'b1;
          flush_c     = 1'b1;
          flush_inc_c = 1'b1;
          state_nxt   = BR_NEXT;
          left_nxt    = RELOAD_V;
        end else if (load_use) begin
          bubble_c = 1'b1;
        end else if (!imem_ready) begin
          flush_c   = 1'b1;
          state_nxt = ST_WAIT;
          wait_nxt  = WAIT_W'(1);
        end else begin
          pc_we_c   = 1'b1;
          ifid_we_c = 1'b1;
        end
      end

      ST_WAIT: begin
        req_c   = 1'b1;
        flush_c = 1'b1;
        if (branch_taken) begin
          pc_we_c   = 1'b1;
          abort_c   = 1'b1;
          state_nxt = BR_NEXT;
          left_nxt  = RELOAD_V;
          wait_nxt  = '0;
        end else if ((wait_cnt == TIMEOUT_V) && !imem_ready) begin
          // PC is held, so returning to RUN reissues the same fetch.
          abort_c   = 1'b1;
          err_set_c = 1'b1;
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end else if (load_use) begin
          // Hold the fetch while ID stalls; the wait count saturates at the limit.
          bubble_c = 1'b1;
          if (wait_cnt != TIMEOUT_V) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end else if (imem_ready) begin
          pc_we_c   = 1'b1;
          ifid_we_c = 1'b1;
          flush_c   = 1'b0;
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end

      ST_FLUSH: begin
        // ID holds a flushed NOP here, so load-use cannot apply.
        req_c       = 1'b1;
        flush_c     = 1'b1;
        flush_inc_c = 1'b1;
        if (branch_taken) begin
          pc_we_c  = 1'b1;
          left_nxt = RELOAD_V;
        end else if (imem_ready) begin
          pc_we_c  = 1'b1;
          left_nxt = flush_left - LEFT_W'(1);
          if (flush_left == LEFT_W'(1)) begin
            state_nxt = ST_RUN;
          end
        end
      end

      default: begin
        state_nxt = ST_RUN;
        wait_nxt  = '0;
        left_nxt  = '0;
      end
    endcase

    stall_inc_c = !pc_we_c && (state != ST_FLUSH);
  end

  // Controls are forced low while reset is held.
  assign imem_req    = rst_n & req_c;
  assign imem_abort  = rst_n & abort_c;
  assign pc_we       = rst_n & pc_we_c;
  assign ifid_we     = rst_n & ifid_we_c & ~flush_c;
  assign ifid_flush  = rst_n & flush_c;
  assign idex_bubble = rst_n & bubble_c;

  // State, wait counter and flush countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      wait_cnt   <= '0;
      flush_left <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      flush_left <= left_nxt;
    end
  end

  // Sticky timeout flag and saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_err  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (err_set_c) begin
        imem_err <= 1'b1;
      end
      if (stall_inc_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_inc_c && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Self-checking bench for fetch_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_fetch_hazard_ctrl;

  localparam int unsigned FC    = 2;
  localparam int unsigned TO    = 4;
  localparam int unsigned CW    = 6;
  localparam int          CMAX  = (1 << CW) - 1;

  localparam int M_RUN   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_FLUSH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read, branch_taken, imem_ready;
  logic          imem_req, imem_abort, pc_we, ifid_we, ifid_flush, idex_bubble, imem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  fetch_hazard_ctrl #(.FLUSH_CYCLES(FC), .IMEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_abort(imem_abort), .pc_we(pc_we),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .imem_err(imem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state (committed on the rising edge).
  int  m_mode, m_waited, m_left, m_err, m_stall, m_flush;
  int  n_mode, n_waited, n_left, n_err, n_stall, n_flush;
  bit  have_next = 1'b0;

  // Compare process: derive what every output must be this cycle and check it.
  always @(negedge clk) begin
    int  e_req, e_abort, e_pc, e_we, e_fl, e_bub, from_branch;
    bit  hazard;
    if (!rst_n) begin
      have_next = 1'b0;
      chk("rst_req", imem_req, 0);    chk("rst_abort", imem_abort, 0);
      chk("rst_pc_we", pc_we, 0);     chk("rst_ifid_we", ifid_we, 0);
      chk("rst_flush", ifid_flush, 0); chk("rst_bubble", idex_bubble, 0);
      chk("rst_err", imem_err, 0);
      chk("rst_stall_cnt", int'(stall_cnt), 0);
      chk("rst_flush_cnt", int'(flush_cnt), 0);
    end else begin
      hazard = ex_mem_read && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
      e_req = 1; e_abort = 0; e_pc = 0; e_we = 0; e_fl = 0; e_bub = 0; from_branch = 0;
      n_mode = m_mode; n_waited = m_waited; n_left = m_left; n_err = m_err;
      if (m_mode == M_RUN) begin
        if (branch_taken) begin
          e_pc = 1; e_fl = 1; from_branch = 1;
          n_mode = (FC > 1) ? M_FLUSH : M_RUN; n_left = FC - 1;
        end else if (hazard) e_bub = 1;
        else if (!imem_ready) begin e_fl = 1; n_mode = M_WAIT; n_waited = 1; end
        else begin e_pc = 1; e_we = 1; end
      end else if (m_mode == M_WAIT) begin
        e_fl = 1;
        if (branch_taken) begin
          e_pc = 1; e_abort = 1; n_mode = (FC > 1) ? M_FLUSH : M_RUN; n_left = FC - 1;
        end else if (m_waited == TO && !imem_ready) begin
          e_abort = 1; n_err = 1; n_mode = M_RUN;
        end else if (hazard) begin
          e_bub = 1; n_waited = (m_waited + 1 > TO) ? TO : m_waited + 1;
        end else if (imem_ready) begin
          e_pc = 1; e_we = 1; e_fl = 0; n_mode = M_RUN;
        end else n_waited = m_waited + 1;
      end else begin
        e_fl = 1; from_branch = 1;
        if (branch_taken) begin e_pc = 1; n_left = FC - 1; end
        else if (imem_ready) begin
          e_pc = 1; n_left = m_left - 1;
          if (n_left == 0) n_mode = M_RUN;
        end
      end
      n_stall = m_stall + ((e_pc == 0 && m_mode != M_FLUSH) ? 1 : 0);
      if (n_stall > CMAX) n_stall = CMAX;
      n_flush = m_flush + from_branch;
      if (n_flush > CMAX) n_flush = CMAX;
      have_next = 1'b1;

      chk("imem_req", imem_req, e_req);     chk("imem_abort", imem_abort, e_abort);
      chk("pc_we", pc_we, e_pc);            chk("ifid_we", ifid_we, e_we);
      chk("ifid_flush", ifid_flush, e_fl);  chk("idex_bubble", idex_bubble, e_bub);
      chk("imem_err", imem_err, m_err);
      chk("stall_cnt", int'(stall_cnt), m_stall);
      chk("flush_cnt", int'(flush_cnt), m_flush);
    end
  end

  // Model register update, mirroring the asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_RUN; m_waited <= 0; m_left <= 0; m_err <= 0; m_stall <= 0; m_flush <= 0;
      have_next <= 1'b0;
    end else if (have_next) begin
      m_mode <= n_mode; m_waited <= n_waited; m_left <= n_left;
      m_err <= n_err; m_stall <= n_stall; m_flush <= n_flush;
      have_next <= 1'b0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    branch_taken = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
  endtask

  int drought;

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; quiet();
    repeat (2) next_cycle();
    chk("lit_rst_req", imem_req, 0);
    chk("lit_rst_stall", int'(stall_cnt), 0);
    rst_n = 1'b1;

    // Clean streaming fetch.
    for (int i = 0; i < 4; i++) begin
      #1; chk("lit_run_pc_we", pc_we, 1); chk("lit_run_ifid_we", ifid_we, 1);
      next_cycle();
    end
    chk("lit_run_stall", int'(stall_cnt), 0);
    chk("lit_run_flush", int'(flush_cnt), 0);

    // Load-use for one cycle, then the r0 case that must not stall.
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1; chk("lit_lu_pc_we", pc_we, 0); chk("lit_lu_ifid_we", ifid_we, 0);
    chk("lit_lu_bubble", idex_bubble, 1);
    next_cycle();
    quiet();
    #1; chk("lit_lu_after_pc", pc_we, 1); chk("lit_lu_after_bub", idex_bubble, 0);
    chk("lit_lu_stall", int'(stall_cnt), 1);
    next_cycle();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1; chk("lit_r0_pc_we", pc_we, 1); chk("lit_r0_bubble", idex_bubble, 0);
    next_cycle();
    quiet();
    chk("lit_r0_stall", int'(stall_cnt), 1);

    // Taken branch: two flush cycles, PC loads on the first.
    branch_taken = 1'b1;
    #1; chk("lit_br_pc_we", pc_we, 1); chk("lit_br_flush", ifid_flush, 1);
    chk("lit_br_bubble", idex_bubble, 0);
    next_cycle();
    branch_taken = 1'b0;
    #1; chk("lit_br_flush2", ifid_flush, 1); chk("lit_br_pc_we2", pc_we, 1);
    next_cycle();
    #1; chk("lit_br_flush3", ifid_flush, 0);
    chk("lit_br_flush_cnt", int'(flush_cnt), 2);

    // IMEM not ready for three cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("lit_wait_pc_we", pc_we, 0); chk("lit_wait_flush", ifid_flush, 1);
      next_cycle();
    end
    imem_ready = 1'b1;
    #1; chk("lit_ready_pc_we", pc_we, 1); chk("lit_ready_ifid_we", ifid_we, 1);
    chk("lit_ready_flush", ifid_flush, 0);
    next_cycle();
    chk("lit_wait_stall", int'(stall_cnt), 4);

    // Timeout: abort on the fourth wait cycle, error sticks, fetch reissued.
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; chk("lit_to_abort", imem_abort, (i == 4) ? 1 : 0);
      next_cycle();
    end
    imem_ready = 1'b1;
    chk("lit_to_err", imem_err, 1); chk("lit_to_req", imem_req, 1);
    #1; chk("lit_to_pc_we", pc_we, 1); chk("lit_to_ifid_we", ifid_we, 1);
    next_cycle();
    chk("lit_to_stall", int'(stall_cnt), 9);
    next_cycle();
    chk("lit_to_err_sticky", imem_err, 1);

    // Branch beats load-use and a not-ready memory in the same cycle.
    branch_taken = 1'b1; imem_ready = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
    #1; chk("lit_pri_pc_we", pc_we, 1); chk("lit_pri_flush", ifid_flush, 1);
    chk("lit_pri_bubble", idex_bubble, 0);
    next_cycle();
    quiet(); imem_ready = 1'b1;
    #1; chk("lit_pri_flush2", ifid_flush, 1);
    next_cycle();
    chk("lit_pri_flush_cnt", int'(flush_cnt), 4);

    // Reset in the middle of an IMEM wait clears everything at once.
    imem_ready = 1'b0;
    next_cycle();
    #1; rst_n = 1'b0;
    #1;
    chk("lit_mr_req", imem_req, 0); chk("lit_mr_abort", imem_abort, 0);
    chk("lit_mr_pc_we", pc_we, 0);  chk("lit_mr_flush", ifid_flush, 0);
    chk("lit_mr_err", imem_err, 0); chk("lit_mr_stall", int'(stall_cnt), 0);
    chk("lit_mr_flush_cnt", int'(flush_cnt), 0);
    next_cycle();
    rst_n = 1'b1; imem_ready = 1'b1;

    // Randomized traffic; the compare process checks every cycle.
    drought = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n        = ($urandom_range(0, 399) != 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      if (drought > 0) begin
        imem_ready = 1'b0; drought--;
      end else if ($urandom_range(0, 29) == 0) begin
        imem_ready = 1'b0; drought = $urandom_range(3, 8);
      end else begin
        imem_ready = ($urandom_range(0, 3) != 0);
      end
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rt       = 5'($urandom_range(0, 3));
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_uses_rt  = ($urandom_range(0, 1) == 1);
      next_cycle();
    end
    rst_n = 1'b1; quiet(); imem_ready = 1'b1;
    repeat (2) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
